// File: rtl/snake_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : snake_pkg                                                 |
// | Purpose  : Shared types and constants for the snake game blocks:     |
// |            controller state encoding, coordinate width, body-segment |
// |            limit, start position and the segment-valid helper.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package snake_pkg;

  localparam int COORD_W  = 5;
  localparam int MAX_BODY = 4;
  localparam logic [COORD_W-1:0] INIT_POS = 5'd24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RELOC = 3'd4,
    ST_DEAD  = 3'd5
  } state_t;

  // (0,0) marks an unused body slot in snake_pos.
  function automatic logic seg_valid(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    return (x != '0) || (y != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_food_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : snake_food_lfsr                                           |
// | Purpose  : 10-bit Fibonacci LFSR (x^10 + x^7 + 1), free running,     |
// |            source of food relocation candidates.                     |
// | Ports    : clk  - system clock, rising edge                          |
// |            rst  - synchronous active-high reset, loads SEED          |
// |            rnd  - current LFSR state                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module snake_food_lfsr #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] rnd
);

  logic [9:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end
  end

  assign rnd = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/snake_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : snake_ctrl                                                |
// | Purpose  : Game-rule controller for snake_pos: move pacing, food     |
// |            capture and relocation, self-collision and score.         |
// | Ports    : clk, rst           - clock / sync active-high reset       |
// |            start              - level, leaves IDLE                   |
// |            head_x/y           - head coordinate from snake_pos       |
// |            snake_x1..4/y1..4  - body segments, (0,0) = unused        |
// |            enable             - one-cycle move strobe                |
// |            grow               - grow instead of move (with enable)   |
// |            die                - high while dead                      |
// |            food_x/y           - current food coordinate              |
// |            score              - foods eaten, saturating              |
// |            state              - FSM state for debug/display          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter logic [9:0]  SEED     = 10'h2A5,
  parameter logic [4:0]  FOOD_X0  = 5'd5,
  parameter logic [4:0]  FOOD_Y0  = 5'd7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] snake_x1,
  input  logic [COORD_W-1:0] snake_y1,
  input  logic [COORD_W-1:0] snake_x2,
  input  logic [COORD_W-1:0] snake_y2,
  input  logic [COORD_W-1:0] snake_x3,
  input  logic [COORD_W-1:0] snake_y3,
  input  logic [COORD_W-1:0] snake_x4,
  input  logic [COORD_W-1:0] snake_y4,
  output logic               enable,
  output logic               grow,
  output logic               die,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic [7:0]         score,
  output logic [2:0]         state
);

  localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(TICK_DIV - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_tick_pend;
  logic [2:0]           r_body_len;
  logic                 r_eat_pend;
  logic [7:0]           r_score;
  logic [COORD_W-1:0]   r_food_x;
  logic [COORD_W-1:0]   r_food_y;
  logic                 r_enable;
  logic                 r_grow;
  logic                 r_die;
  logic [9:0]           w_rnd;
  logic [COORD_W-1:0]   w_body_x [MAX_BODY];
  logic [COORD_W-1:0]   w_body_y [MAX_BODY];
  logic                 w_hit_body;
  logic                 w_hit_food;
  logic                 w_cand_ok;
  logic                 w_tick_done;
  logic                 w_enable_d;
  logic                 w_grow_d;
  logic                 w_die_d;

  snake_food_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (w_rnd)
  );

  assign w_body_x[0] = snake_x1;
  assign w_body_y[0] = snake_y1;
  assign w_body_x[1] = snake_x2;
  assign w_body_y[1] = snake_y2;
  assign w_body_x[2] = snake_x3;
  assign w_body_y[2] = snake_y3;
  assign w_body_x[3] = snake_x4;
  assign w_body_y[3] = snake_y4;

  always_comb begin
    w_hit_body = 1'b0;
    for (int i = 0; i < MAX_BODY; i++) begin
      if (seg_valid(w_body_x[i], w_body_y[i]) &&
          (w_body_x[i] == head_x) && (w_body_y[i] == head_y)) begin
        w_hit_body = 1'b1;
      end
    end
  end

  assign w_hit_food  = (head_x == r_food_x) && (head_y == r_food_y);
  // Candidate food is {x,y} = rnd[9:5], rnd[4:0].
  assign w_cand_ok   = seg_valid(w_rnd[9:5], w_rnd[4:0]) &&
                       !((w_rnd[9:5] == head_x) && (w_rnd[4:0] == head_y));
  assign w_tick_done = (r_cnt == c_tick_last);

  // Next-state logic. A tick that expires during RELOC is remembered in
  // r_tick_pend so leaving RELOC goes straight to STEP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_RUN;
      ST_RUN:   if (w_tick_done) w_next_state = ST_STEP;
      ST_STEP:  w_next_state = ST_CHECK;
      ST_CHECK: begin
        if (w_hit_body)      w_next_state = ST_DEAD;
        else if (w_hit_food) w_next_state = ST_RELOC;
        else                 w_next_state = ST_RUN;
      end
      ST_RELOC: begin
        if (w_cand_ok) begin
          w_next_state = (r_tick_pend || w_tick_done) ? ST_STEP : ST_RUN;
        end
      end
      ST_DEAD:  w_next_state = ST_DEAD;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output decode against the next state so the strobes are registered
  // and line up exactly with the STEP / DEAD cycles.
  always_comb begin
    w_enable_d = (w_next_state == ST_STEP);
    w_grow_d   = w_enable_d && r_eat_pend && (r_body_len < 3'(MAX_BODY));
    w_die_d    = (w_next_state == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tick_pend <= 1'b0;
      r_body_len  <= '0;
      r_eat_pend  <= 1'b0;
      r_score     <= '0;
      r_food_x    <= FOOD_X0;
      r_food_y    <= FOOD_Y0;
      r_enable    <= 1'b0;
      r_grow      <= 1'b0;
      r_die       <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_enable <= w_enable_d;
      r_grow   <= w_grow_d;
      r_die    <= w_die_d;
      case (r_state)
        ST_IDLE: r_cnt <= '0;
        ST_RUN:  r_cnt <= w_tick_done ? '0 : r_cnt + c_cnt_w'(1);
        ST_STEP: begin
          r_eat_pend <= 1'b0;
          if (r_grow) r_body_len <= r_body_len + 3'd1;
        end
        ST_CHECK: begin
          if (!w_hit_body && w_hit_food) begin
            r_eat_pend <= 1'b1;
            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
          end
        end
        ST_RELOC: begin
          if (w_cand_ok) begin
            r_food_x <= w_rnd[9:5];
            r_food_y <= w_rnd[4:0];
          end
          if (w_next_state == ST_STEP) begin
            r_cnt       <= '0;
            r_tick_pend <= 1'b0;
          end else if (w_tick_done) begin
            r_cnt       <= '0;
            r_tick_pend <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign enable = r_enable;
  assign grow   = r_grow;
  assign die    = r_die;
  assign food_x = r_food_x;
  assign food_y = r_food_y;
  assign score  = r_score;
  assign state  = r_state;

endmodule
`default_nettype wire
